rr_queue_bank: RTL and testbench

- Multi-queue FIFO bank sitting upstream of the weighted round-robin arbiter.
- Write side: demultiplexes an ingress valid/ready word stream into QUEUE_QUANTITY independent FIFOs, selected by a destination field.
- Read side: pops the queue named by the arbiter's selector/selector_enb.
- Exports buf_empty and fifo_counter in the exact packing the arbiter consumes.

---
 rtl/rr_queue_bank.sv | 118 +++++++++++
 tb/tb_rr_queue_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_queue_bank.sv
// Bank of QUEUE_QUANTITY independent FIFOs. Pushes are steered by push_dest,
// pops by the arbiter's selector. Status flags come out in the packing the arbiter reads.
module rr_queue_bank #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int DATA_BITS      = 8,
   parameter int BUF_WIDTH      = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  enb,
   input  logic                                  push_valid,
   input  logic [$clog2(QUEUE_QUANTITY)-1:0]     push_dest,
   input  logic [DATA_BITS-1:0]                  push_data,
   output logic                                  push_ready,
   input  logic [$clog2(QUEUE_QUANTITY)-1:0]     selector,
   input  logic                                  selector_enb,
   output logic [DATA_BITS-1:0]                  data_out,
   output logic                                  data_out_valid,
   output logic [QUEUE_QUANTITY-1:0]             buf_empty,
   output logic [QUEUE_QUANTITY-1:0]             buf_full,
   output logic [QUEUE_QUANTITY*BUF_WIDTH-1:0]   fifo_counter,
   output logic                                  pop_err
);

   localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);
   localparam int PTR_BITS = BUF_WIDTH - 1;
   localparam int DEPTH    = 2**PTR_BITS;
   localparam logic [BUF_WIDTH-1:0] DEPTH_CNT = BUF_WIDTH'(DEPTH);

   // All queues share one array, addressed as {queue index, pointer}
   logic [DATA_BITS-1:0] mem [QUEUE_QUANTITY*DEPTH];

   logic [PTR_BITS-1:0]  wr_ptr_reg [QUEUE_QUANTITY];
   logic [PTR_BITS-1:0]  rd_ptr_reg [QUEUE_QUANTITY];
   logic [BUF_WIDTH-1:0] count_reg  [QUEUE_QUANTITY];
   logic                 empty_reg  [QUEUE_QUANTITY];
   logic                 full_reg   [QUEUE_QUANTITY];

   logic [DATA_BITS-1:0] data_out_reg;
   logic                 data_out_valid_reg;
   logic                 pop_err_reg;

   logic                 push_acc;
   logic                 pop_acc;
   logic                 pop_miss;
   logic [QUEUE_QUANTITY-1:0] push_hit;
   logic [QUEUE_QUANTITY-1:0] pop_hit;

   // Readiness depends only on registered state, never on the pop inputs
   assign push_ready = enb & rst & ~full_reg[push_dest];
   assign push_acc   = push_valid & push_ready;
   assign pop_acc    = enb & selector_enb & ~empty_reg[selector];
   assign pop_miss   = enb & selector_enb & empty_reg[selector];

   always_ff @(posedge clk) begin
      if (push_acc)
         mem[{push_dest, wr_ptr_reg[push_dest]}] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_reg       <= '0;
         data_out_valid_reg <= 1'b0;
         pop_err_reg        <= 1'b0;
      end else begin
         data_out_valid_reg <= pop_acc;
         pop_err_reg        <= pop_miss;
         if (pop_acc)
            data_out_reg <= mem[{selector, rd_ptr_reg[selector]}];
      end
   end

   assign data_out       = data_out_reg;
   assign data_out_valid = data_out_valid_reg;
   assign pop_err        = pop_err_reg;

   genvar gi;
   generate
      for (gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_queue
         logic [BUF_WIDTH-1:0] count_next;

         assign push_hit[gi] = push_acc & (push_dest == SEL_BITS'(gi));
         assign pop_hit[gi]  = pop_acc  & (selector  == SEL_BITS'(gi));

         always_comb begin
            count_next = count_reg[gi];
            if (push_hit[gi] && !pop_hit[gi])
               count_next = count_reg[gi] + BUF_WIDTH'(1);
            else if (!push_hit[gi] && pop_hit[gi])
               count_next = count_reg[gi] - BUF_WIDTH'(1);
         end

         // Flags are registered from count_next so they track the count exactly
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wr_ptr_reg[gi] <= '0;
               rd_ptr_reg[gi] <= '0;
               count_reg[gi]  <= '0;
               empty_reg[gi]  <= 1'b1;
               full_reg[gi]   <= 1'b0;
            end else begin
               if (push_hit[gi])
                  wr_ptr_reg[gi] <= wr_ptr_reg[gi] + PTR_BITS'(1);
               if (pop_hit[gi])
                  rd_ptr_reg[gi] <= rd_ptr_reg[gi] + PTR_BITS'(1);
               count_reg[gi] <= count_next;
               empty_reg[gi] <= (count_next == '0);
               full_reg[gi]  <= (count_next == DEPTH_CNT);
            end
         end

         assign buf_empty[gi] = empty_reg[gi];
         assign buf_full[gi]  = full_reg[gi];
         assign fifo_counter[gi*BUF_WIDTH +: BUF_WIDTH] = count_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_rr_queue_bank.sv
// Bench for rr_queue_bank: directed scenarios then random traffic, all compared
// against a queue-of-words model of the bank.
module tb_rr_queue_bank;

   localparam int QN    = 4;
   localparam int DW    = 8;
   localparam int BW    = 4;
   localparam int DEPTH = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            enb;
   logic            push_valid;
   logic [1:0]      push_dest;
   logic [DW-1:0]   push_data;
   logic            push_ready;
   logic [1:0]      selector;
   logic            selector_enb;
   logic [DW-1:0]   data_out;
   logic            data_out_valid;
   logic [QN-1:0]   buf_empty;
   logic [QN-1:0]   buf_full;
   logic [QN*BW-1:0] fifo_counter;
   logic            pop_err;

   rr_queue_bank #(.QUEUE_QUANTITY(QN), .DATA_BITS(DW), .BUF_WIDTH(BW)) dut (
      .clk(clk), .rst(rst), .enb(enb),
      .push_valid(push_valid), .push_dest(push_dest), .push_data(push_data),
      .push_ready(push_ready), .selector(selector), .selector_enb(selector_enb),
      .data_out(data_out), .data_out_valid(data_out_valid),
      .buf_empty(buf_empty), .buf_full(buf_full),
      .fifo_counter(fifo_counter), .pop_err(pop_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: one word queue per FIFO plus the expected output registers
   logic [DW-1:0] m_q [QN][$];
   logic [DW-1:0] exp_dout  = '0;
   logic          exp_valid = 1'b0;
   logic          exp_err   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < QN; i++) m_q[i].delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
   endtask

   task automatic check_state();
      logic [QN-1:0]    e_empty;
      logic [QN-1:0]    e_full;
      logic [QN*BW-1:0] e_cnt;
      for (int i = 0; i < QN; i++) begin
         e_empty[i] = (m_q[i].size() == 0);
         e_full[i]  = (m_q[i].size() == DEPTH);
         e_cnt[i*BW +: BW] = BW'(m_q[i].size());
      end
      check("data_out_valid", 32'(data_out_valid), 32'(exp_valid));
      check("pop_err", 32'(pop_err), 32'(exp_err));
      check("data_out", 32'(data_out), 32'(exp_dout));
      check("buf_empty", 32'(buf_empty), 32'(e_empty));
      check("buf_full", 32'(buf_full), 32'(e_full));
      check("fifo_counter", 32'(fifo_counter), 32'(e_cnt));
   endtask

   // One clock of traffic; called just after a rising edge
   task automatic cycle(input bit v, input int d, input logic [DW-1:0] dat,
                        input bit se, input int s, input bit e);
      bit exp_ready, do_push, do_pop, miss;
      push_valid   = v;
      push_dest    = 2'(d);
      push_data    = dat;
      selector_enb = se;
      selector     = 2'(s);
      enb          = e;
      #1;
      exp_ready = e && (m_q[d].size() < DEPTH);
      check("push_ready", 32'(push_ready), 32'(exp_ready));
      do_push = v && exp_ready;
      do_pop  = e && se && (m_q[s].size() > 0);
      miss    = e && se && (m_q[s].size() == 0);
      @(posedge clk);
      #1;
      exp_valid = do_pop;
      exp_err   = miss;
      if (do_pop) exp_dout = m_q[s].pop_front();
      if (do_push) m_q[d].push_back(dat);
      check_state();
   endtask

   initial begin
      rst = 1'b0; enb = 1'b1; push_valid = 1'b0; push_dest = '0; push_data = '0;
      selector = '0; selector_enb = 1'b0;
      model_reset();
      repeat (4) @(posedge clk);
      #1;
      check("push_ready_in_reset", 32'(push_ready), 32'd0);
      check_state();
      check("reset_empty_const", 32'(buf_empty), 32'hF);
      rst = 1'b1;
      #1;
      check("push_ready_after_reset", 32'(push_ready), 32'd1);

      // Queue 2: three words in, three out
      cycle(1, 2, 8'hA1, 0, 0, 1);
      cycle(1, 2, 8'hA2, 0, 0, 1);
      cycle(1, 2, 8'hA3, 0, 0, 1);
      check("q2_count3", 32'(fifo_counter[11:8]), 32'd3);
      cycle(0, 0, 8'h00, 1, 2, 1);
      check("q2_first_word", 32'(data_out), 32'hA1);
      cycle(0, 0, 8'h00, 1, 2, 1);
      cycle(0, 0, 8'h00, 1, 2, 1);
      check("q2_last_word", 32'(data_out), 32'hA3);
      check("q2_empty_again", 32'(buf_empty[2]), 32'd1);

      // Queue 0 to full, ready per destination, ignored ninth push, drain across wrap
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'(8'h10 + i), 0, 0, 1);
      check("q0_full", 32'(buf_full[0]), 32'd1);
      cycle(0, 0, 8'h00, 0, 0, 1);
      cycle(0, 1, 8'h00, 0, 0, 1);
      cycle(1, 0, 8'hEE, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'h00, 1, 0, 1);
      check("q0_last_word", 32'(data_out), 32'h17);

      // Queue 1: four words, then five cycles of simultaneous push and pop
      for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'h20 + i), 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(1, 1, 8'(8'h30 + i), 1, 1, 1);
      check("q1_count_steady", 32'(fifo_counter[7:4]), 32'd4);
      check("q1_fifth_out", 32'(data_out), 32'h30);

      // Pop an empty queue 3 while pushing to it: no fall-through
      cycle(1, 3, 8'h5C, 1, 3, 1);
      check("q3_pop_err", 32'(pop_err), 32'd1);
      check("q3_count1", 32'(fifo_counter[15:12]), 32'd1);

      // Queue 0: five words, then three disabled cycles with requests active
      for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h40 + i), 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 8'h99, 1, 0, 0);
      check("q0_held", 32'(fifo_counter[3:0]), 32'd5);

      // Reset mid-stream takes effect without a clock edge
      cycle(1, 0, 8'h45, 1, 0, 1);
      rst = 1'b0;
      #2;
      model_reset();
      check_state();
      check("midreset_empty", 32'(buf_empty), 32'hF);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cycle(1, 0, 8'h77, 0, 0, 1);
      cycle(0, 0, 8'h00, 1, 0, 1);
      check("post_reset_word", 32'(data_out), 32'h77);

      // Random traffic, with phases biased toward filling and toward draining
      for (int i = 0; i < 600; i++) begin
         bit fill_phase;
         fill_phase = ((i / 100) % 2) == 0;
         cycle(($urandom_range(0, 9) < (fill_phase ? 8 : 3)),
               int'($urandom_range(0, QN-1)), 8'($urandom),
               ($urandom_range(0, 9) < (fill_phase ? 3 : 8)),
               int'($urandom_range(0, QN-1)),
               ($urandom_range(0, 7) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
